led_pio_sequencer: RTL and testbench

LED_PIO_SEQUENCER -- requirements
Module: led_pio_sequencer

---
 rtl/led_pio_sequencer_pkg.sv | 37 +++
 rtl/led_pio_sequencer_if.sv | 41 ++++
 rtl/led_pio_seq_timer.sv | 29 ++
 rtl/led_pio_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_led_pio_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pio_sequencer_pkg.sv
// Shared definitions for the LED PIO sequencer: FSM state encoding, CSR word
// offsets, CTRL/STATUS bit positions and the LENGTH clamp helper.
// Optional feature macro used elsewhere: LED_PIO_SEQUENCER_IRQ_EN.
package led_pio_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] CSR_CTRL    = 3'd0;
  localparam logic [2:0] CSR_PERIOD  = 3'd1;
  localparam logic [2:0] CSR_INDEX   = 3'd2;
  localparam logic [2:0] CSR_PATTERN = 3'd3;
  localparam logic [2:0] CSR_LENGTH  = 3'd4;
  localparam logic [2:0] CSR_STATUS  = 3'd5;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_STEP_LSB = 4;
  localparam int STEP_FIELD_W  = 3;

  // LENGTH of 0 still plays one step; anything beyond the table plays it all.
  function automatic int unsigned eff_length(input logic [3:0] len, input int unsigned depth);
    int unsigned l;
    l = 32'(len);
    if (l == 0) l = 1;
    if (l > depth) l = depth;
    return l;
  endfunction

endpackage

// File: rtl/led_pio_sequencer_if.sv
// Bus bundle for the LED PIO sequencer: CSR slave side and PIO master side.
// The irq line exists only when LED_PIO_SEQUENCER_IRQ_EN is defined.
//
// Handshake: a PIO write transfers on the cycle where m_chipselect=1,
// m_write_n=0 and m_waitrequest=0. While m_waitrequest=1 the sequencer holds
// m_address/m_writedata/m_chipselect/m_write_n unchanged. CSR accesses are
// single-cycle: a write lands on the clock edge where chipselect=1 and
// write_n=0; readdata follows address combinationally.
interface led_pio_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
`ifdef LED_PIO_SEQUENCER_IRQ_EN
  logic        irq;
`endif

  // Host / environment side: drives CSR accesses and answers PIO writes.
  modport master (
    output address, chipselect, write_n, writedata, m_waitrequest,
    input  readdata, m_address, m_chipselect, m_write_n, m_writedata
`ifdef LED_PIO_SEQUENCER_IRQ_EN
    , input irq
`endif
  );

  // Sequencer side.
  modport slave (
    input  address, chipselect, write_n, writedata, m_waitrequest,
    output readdata, m_address, m_chipselect, m_write_n, m_writedata
`ifdef LED_PIO_SEQUENCER_IRQ_EN
    , output irq
`endif
  );
endinterface

// File: rtl/led_pio_seq_timer.sv
// Step-period down-counter. A load arms it with max(PERIOD,1)-1; while
// enabled it counts to zero and o_expire is high on the final WAIT cycle.
module led_pio_seq_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_en,
  output logic                o_expire
);

  logic [PERIOD_W-1:0] r_cnt;

  // Load on WRITE acceptance, count down through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_period == '0) ? '0 : i_period - PERIOD_W'(1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - PERIOD_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/led_pio_sequencer.sv
// LED PIO sequencer: plays a small pattern table out to an Avalon-style PIO,
// one pattern per step, with a programmable step period.
// Optional feature: define LED_PIO_SEQUENCER_IRQ_EN to add the irq output,
// the CTRL IRQ-enable bit and write-1-to-clear of STATUS.DONE.
module led_pio_sequencer
  import led_pio_sequencer_pkg::*;
#(
  parameter int LED_W    = 10,
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
`ifdef LED_PIO_SEQUENCER_IRQ_EN
  , output logic      irq
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state, w_state_nxt;
  logic               r_run, r_loop, r_done;
  logic [PERIOD_W-1:0] r_period;
  logic [3:0]         r_length;
  logic [IDX_W-1:0]   r_index, r_step, w_fetch_step;
  logic [LED_W-1:0]   r_table [DEPTH];
  logic [LED_W-1:0]   r_wdata;
  logic [IDX_W:0]     w_eff_len;
  logic               w_csr_wr, w_fetch, w_set_done, w_clr_run, w_start;
  logic               w_timer_load, w_expire, w_last, w_wr_active;
  logic               w_unused;
`ifdef LED_PIO_SEQUENCER_IRQ_EN
  logic               r_irq_en;
`endif

  assign w_csr_wr  = chipselect & ~write_n;
  assign w_eff_len = (IDX_W+1)'(eff_length(r_length, DEPTH));
  assign w_last    = ({1'b0, r_step} == (w_eff_len - (IDX_W+1)'(1)));
  assign w_unused  = ^writedata;

  led_pio_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_load   (w_timer_load),
    .i_period (r_period),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  // CSR registers plus the FSM side-effects on RUN and DONE; a CSR write in
  // the same cycle overrides the FSM clearing RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_loop   <= 1'b0;
      r_done   <= 1'b0;
      r_period <= PERIOD_W'(1);
      r_length <= 4'd1;
      r_index  <= '0;
`ifdef LED_PIO_SEQUENCER_IRQ_EN
      r_irq_en <= 1'b0;
`endif
    end else begin
      if (w_clr_run) r_run <= 1'b0;
      if (w_start) r_done <= 1'b0;
      else if (w_set_done) r_done <= 1'b1;
      if (w_csr_wr) begin
        case (address)
          CSR_CTRL: begin
            r_run  <= writedata[CTRL_RUN];
            r_loop <= writedata[CTRL_LOOP];
`ifdef LED_PIO_SEQUENCER_IRQ_EN
            r_irq_en <= writedata[CTRL_IRQ_EN];
`endif
          end
          CSR_PERIOD:  r_period <= writedata[PERIOD_W-1:0];
          CSR_INDEX:   r_index  <= writedata[IDX_W-1:0];
          CSR_PATTERN: r_index  <= r_index + IDX_W'(1);
          CSR_LENGTH:  r_length <= writedata[3:0];
`ifdef LED_PIO_SEQUENCER_IRQ_EN
          CSR_STATUS:  if (writedata[STAT_DONE]) r_done <= 1'b0;
`endif
          default: ;
        endcase
      end
    end
  end

  // Pattern table; written at INDEX through the PATTERN window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (w_csr_wr && (address == CSR_PATTERN)) begin
      r_table[r_index] <= writedata[LED_W-1:0];
    end
  end

  // Fetch captures the table entry into the write holding register, so a
  // PATTERN update in the fetch cycle only affects later fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step  <= '0;
      r_wdata <= '0;
    end else if (w_fetch) begin
      r_step  <= w_fetch_step;
      r_wdata <= r_table[w_fetch_step];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and control strobes. RUN is only ever 1 in IDLE right
  // after software sets it, so leaving IDLE on RUN=1 is the 0->1 start.
  always_comb begin
    w_state_nxt  = r_state;
    w_fetch      = 1'b0;
    w_fetch_step = r_step;
    w_set_done   = 1'b0;
    w_clr_run    = 1'b0;
    w_start      = 1'b0;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_run) begin
          w_start      = 1'b1;
          w_fetch      = 1'b1;
          w_fetch_step = '0;
          w_state_nxt  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          if (r_run) begin
            w_timer_load = 1'b1;
            w_state_nxt  = ST_WAIT;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (!r_run) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          if (!w_last) begin
            w_fetch      = 1'b1;
            w_fetch_step = r_step + IDX_W'(1);
            w_state_nxt  = ST_WRITE;
          end else if (r_loop) begin
            w_fetch      = 1'b1;
            w_fetch_step = '0;
            w_state_nxt  = ST_WRITE;
          end else begin
            w_set_done  = 1'b1;
            w_clr_run   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr_active  = (r_state == ST_WRITE);
  assign m_address    = 2'b00;
  assign m_chipselect = w_wr_active;
  assign m_write_n    = ~w_wr_active;
  assign m_writedata  = w_wr_active ? 32'(r_wdata) : 32'd0;
`ifdef LED_PIO_SEQUENCER_IRQ_EN
  assign irq = r_done & r_irq_en;
`endif

  // CSR read mux; unused bits and offsets read 0.
  always_comb begin
    readdata = '0;
    case (address)
      CSR_CTRL: begin
        readdata[CTRL_RUN]  = r_run;
        readdata[CTRL_LOOP] = r_loop;
`ifdef LED_PIO_SEQUENCER_IRQ_EN
        readdata[CTRL_IRQ_EN] = r_irq_en;
`endif
      end
      CSR_PERIOD:  readdata[PERIOD_W-1:0] = r_period;
      CSR_INDEX:   readdata[IDX_W-1:0]    = r_index;
      CSR_PATTERN: readdata[LED_W-1:0]    = r_table[r_index];
      CSR_LENGTH:  readdata[3:0]          = r_length;
      CSR_STATUS: begin
        readdata[STAT_BUSY] = (r_state != ST_IDLE);
        readdata[STAT_DONE] = r_done;
        readdata[STAT_STEP_LSB +: STEP_FIELD_W] = STEP_FIELD_W'(r_step);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Testbench for led_pio_sequencer. PIO writes are predicted by a table-walk
// model into exp_q/gap_q; a monitor pops and compares on every accepted write.
// Covers LED_PIO_SEQUENCER_IRQ_EN when that macro is defined.
module tb_led_pio_sequencer;
  import led_pio_sequencer_pkg::*;

  localparam int LED_W = 10;
  localparam int DEPTH = 8;
  localparam int PERIOD_W = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  led_pio_sequencer_if bus();

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int gap_q[$];
  int stall_q[$];
  bit rand_stall = 0;
  int acc_count = 0;
  int first_hold = 0;
  int last_acc = 0;
  logic [LED_W-1:0] tb_table [DEPTH];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  led_pio_sequencer #(.LED_W(LED_W), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (bus.address),
    .chipselect    (bus.chipselect),
    .write_n       (bus.write_n),
    .writedata     (bus.writedata),
    .readdata      (bus.readdata),
    .m_address     (bus.m_address),
    .m_chipselect  (bus.m_chipselect),
    .m_write_n     (bus.m_write_n),
    .m_writedata   (bus.m_writedata),
    .m_waitrequest (bus.m_waitrequest)
`ifdef LED_PIO_SEQUENCER_IRQ_EN
    , .irq         (bus.irq)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PIO slave: answers each new write with a planned, random or zero stall.
  initial begin
    bit in_write;
    int stall_left;
    in_write = 0;
    stall_left = 0;
    bus.m_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && bus.m_chipselect && !bus.m_write_n) begin
        if (!in_write) begin
          in_write = 1;
          if (stall_q.size() > 0) stall_left = stall_q.pop_front();
          else if (rand_stall) stall_left = $urandom_range(0, 3);
          else stall_left = 0;
        end
        if (stall_left > 0) begin
          bus.m_waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.m_waitrequest = 1'b0;
          in_write = 0;
        end
      end else begin
        bus.m_waitrequest = 1'b0;
        in_write = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit pres;
    int hold;
    int g;
    logic [31:0] first_data;
    pres = 0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.m_chipselect && !bus.m_write_n) begin
        if (!pres) begin
          pres = 1;
          hold = 0;
          first_data = bus.m_writedata;
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_write actual=%0h required=none", bus.m_writedata);
          end else if (gap_q[0] != 0) begin
            check("write_gap", cyc - last_acc, gap_q[0]);
          end
        end else begin
          check("hold_stable", bus.m_writedata, first_data);
        end
        hold++;
        if (!bus.m_waitrequest) begin
          pres = 0;
          acc_count++;
          last_acc = cyc;
          check("m_address", 32'(bus.m_address), 32'd0);
          if (exp_q.size() > 0) begin
            g = gap_q.pop_front();
            check("write_data", bus.m_writedata, exp_q.pop_front());
            if (g == 0) first_hold = hold;
          end
        end
      end else begin
        pres = 0;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    n_total++;
    n_bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.writedata = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  function automatic int model_len(input int len);
    if (len == 0) return 1;
    if (len > DEPTH) return DEPTH;
    return len;
  endfunction

  // Reference model: walk the table, one pattern per step, max(P,1)+1 apart.
  task automatic push_expected(input int nwrites, input int period, input int len);
    int eff;
    eff = model_len(len);
    for (int k = 0; k < nwrites; k++) begin
      exp_q.push_back(32'(tb_table[k % eff]));
      gap_q.push_back((k == 0) ? 0 : ((period == 0) ? 1 : period) + 1);
    end
  endtask

  task automatic load_table();
    logic [31:0] d;
    csr_wr(CSR_INDEX, 32'd0);
    for (int i = 0; i < DEPTH; i++)
      csr_wr(CSR_PATTERN, 32'(tb_table[i]) | ($urandom & 32'hFFFF_FC00));
    csr_rd(CSR_INDEX, d);
    check("index_wrap", d, 32'd0);
    csr_rd(CSR_PATTERN, d);
    check("pattern_read", d, 32'(tb_table[0]));
  endtask

  task automatic wait_not_busy(input int budget);
    logic [31:0] s;
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      csr_rd(CSR_STATUS, s);
      if (!s[STAT_BUSY] && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    for (int i = 0; i < budget && acc_count < target; i++) tick();
    check("acc_reached", 32'(acc_count >= target), 32'd1);
  endtask

  task automatic run_oneshot(input int period, input int len);
    logic [31:0] d;
    int eff;
    eff = model_len(len);
    push_expected(eff, period, len);
    csr_wr(CSR_PERIOD, 32'(period));
    csr_wr(CSR_LENGTH, 32'(len));
    csr_wr(CSR_CTRL, 32'h1);
    tick();
    wait_not_busy(eff * (period + 8) + 40);
    csr_rd(CSR_STATUS, d);
    check("oneshot_status", d, (32'((eff - 1) & 7) << 4) | 32'h2);
    csr_rd(CSR_CTRL, d);
    check("oneshot_ctrl", d, 32'd0);
    repeat (8) tick();
  endtask

  task automatic set_table_124();
    for (int i = 0; i < DEPTH; i++) tb_table[i] = '0;
    tb_table[0] = 10'h001;
    tb_table[1] = 10'h002;
    tb_table[2] = 10'h004;
  endtask

  // main stimulus
  initial begin
    logic [31:0] d;
    int base;
    bus.address = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // reset state
    check("rst_cs", 32'(bus.m_chipselect), 32'd0);
    check("rst_wn", 32'(bus.m_write_n), 32'd1);
    check("rst_wdata", bus.m_writedata, 32'd0);
    csr_rd(CSR_CTRL, d);    check("rst_ctrl", d, 32'd0);
    csr_rd(CSR_PERIOD, d);  check("rst_period", d, 32'd1);
    csr_rd(CSR_INDEX, d);   check("rst_index", d, 32'd0);
    csr_rd(CSR_PATTERN, d); check("rst_pattern", d, 32'd0);
    csr_rd(CSR_LENGTH, d);  check("rst_length", d, 32'd1);
    csr_rd(CSR_STATUS, d);  check("rst_status", d, 32'd0);
    csr_rd(3'd6, d);        check("rst_off6", d, 32'd0);
    csr_rd(3'd7, d);        check("rst_off7", d, 32'd0);

    // register widths and the optional IRQ-enable bit
    csr_wr(CSR_PERIOD, 32'hFFFF_FFFF);
    csr_rd(CSR_PERIOD, d);  check("period_width", d, 32'h00FF_FFFF);
    csr_wr(CSR_LENGTH, 32'hFFFF_FFFF);
    csr_rd(CSR_LENGTH, d);  check("length_width", d, 32'h0000_000F);
    csr_wr(CSR_CTRL, 32'h4);
    csr_rd(CSR_CTRL, d);
`ifdef LED_PIO_SEQUENCER_IRQ_EN
    check("ctrl_irq_en", d, 32'h4);
`else
    check("ctrl_irq_en", d, 32'h0);
`endif
    csr_wr(CSR_CTRL, 32'h0);

    // three-step one-shot, period 4
    set_table_124();
    load_table();
    run_oneshot(4, 3);

    // first write stalled three cycles
    stall_q.push_back(3);
    run_oneshot(4, 3);
    check("first_hold", 32'(first_hold), 32'd4);

    // PERIOD=0 and LENGTH above DEPTH
    for (int i = 0; i < DEPTH; i++) tb_table[i] = LED_W'($urandom);
    load_table();
    run_oneshot(0, 9);

    // LENGTH=0 still plays one step
    run_oneshot(2, 0);

    // randomized runs with random stalls
    rand_stall = 1;
    repeat (6) begin
      for (int i = 0; i < DEPTH; i++) tb_table[i] = LED_W'($urandom);
      load_table();
      run_oneshot($urandom_range(0, 6), $urandom_range(0, 15));
    end
    rand_stall = 0;

    // looping: seventh write repeats entry 0, then RUN cleared during WAIT
    set_table_124();
    load_table();
    push_expected(7, 4, 3);
    csr_wr(CSR_PERIOD, 32'd4);
    csr_wr(CSR_LENGTH, 32'd3);
    base = acc_count;
    csr_wr(CSR_CTRL, 32'h3);
    wait_acc(base + 4, 100);
    csr_rd(CSR_STATUS, d);
    check("loop_step_wrap", d, 32'h1);
    wait_acc(base + 7, 100);
    csr_wr(CSR_CTRL, 32'h0);
    wait_not_busy(20);
    csr_rd(CSR_STATUS, d);
    check("loop_stop_status", d, 32'h0);
    check("loop_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (12) tick();

    // reset in the middle of WAIT
    push_expected(1, 10, 3);
    csr_wr(CSR_PERIOD, 32'd10);
    base = acc_count;
    csr_wr(CSR_CTRL, 32'h3);
    wait_acc(base + 1, 50);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_cs", 32'(bus.m_chipselect), 32'd0);
    check("rst_mid_wn", 32'(bus.m_write_n), 32'd1);
    check("rst_mid_wdata", bus.m_writedata, 32'd0);
    csr_rd(CSR_STATUS, d);
    check("rst_mid_status", d, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) tb_table[i] = '0;
    repeat (30) tick();
    csr_rd(CSR_STATUS, d);  check("post_rst_status", d, 32'd0);
    csr_rd(CSR_CTRL, d);    check("post_rst_ctrl", d, 32'd0);
    csr_rd(CSR_PERIOD, d);  check("post_rst_period", d, 32'd1);

    // DONE handling: irq and write-1-to-clear when enabled, sticky otherwise
    set_table_124();
    load_table();
    push_expected(3, 1, 3);
    csr_wr(CSR_PERIOD, 32'd1);
    csr_wr(CSR_LENGTH, 32'd3);
    csr_wr(CSR_CTRL, 32'h5);
    tick();
    wait_not_busy(60);
    csr_rd(CSR_STATUS, d);
    check("done_status", d, 32'h22);
`ifdef LED_PIO_SEQUENCER_IRQ_EN
    check("irq_high", 32'(bus.irq), 32'd1);
    csr_wr(CSR_STATUS, 32'h2);
    check("irq_cleared", 32'(bus.irq), 32'd0);
    csr_rd(CSR_STATUS, d);
    check("done_cleared", d, 32'h20);
`else
    csr_wr(CSR_STATUS, 32'h2);
    csr_rd(CSR_STATUS, d);
    check("done_sticky", d, 32'h22);
`endif
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
